// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with standard or
// first-word-fall-through read, programmable almost-full/almost-empty
// thresholds, occupancy count and overflow/underflow error pulses.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_en,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     r_en,
  output logic [DATA_W-1:0]        data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Thresholds sized to the count width so flag compares stay width-matched.
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];

  // Pointers carry one extra MSB so a full FIFO (difference DEPTH) is
  // distinguishable from an empty one (difference 0).
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] count_reg, count_next;
  logic          full_reg, empty_reg;
  logic          af_reg, ae_reg;
  logic          ovf_reg, unf_reg;
  logic          wr_ok, rd_ok;
  logic [AW-1:0] wr_addr, rd_addr;

  // Accept decisions use the registered flags of the current cycle, so a
  // full FIFO rejects a write even when a read frees a slot on the same edge.
  always_comb begin
    wr_ok       = w_en & ~full_reg;
    rd_ok       = r_en & ~empty_reg;
    wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, wr_ok};
    rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, rd_ok};
    count_next  = wr_ptr_next - rd_ptr_next;
    wr_addr     = wr_ptr_reg[AW-1:0];
    rd_addr     = rd_ptr_reg[AW-1:0];
  end

  // Storage array: write port only, contents are never reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wr_addr] <= data_in;
    end
  end

  // Pointers, count and all flags; flags come from the next count so they
  // always agree with the count register in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      af_reg     <= 1'b0;
      ae_reg     <= 1'b1;
      ovf_reg    <= 1'b0;
      unf_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      full_reg   <= (count_next == DEPTH_C);
      empty_reg  <= (count_next == '0);
      af_reg     <= (count_next >= AF_C);
      ae_reg     <= (count_next <= AE_C);
      ovf_reg    <= w_en & full_reg;
      unf_reg    <= r_en & empty_reg;
    end
  end

  // Read path selected at elaboration time.
  generate
    if (FWFT != 0) begin : g_fwft
      // Head of queue is presented directly; forced to zero while empty so
      // the output matches its reset value instead of stale memory.
      assign data_out = empty_reg ? '0 : mem[rd_addr];
    end else begin : g_std
      logic [DATA_W-1:0] dout_reg;

      // Registered read: popped word appears one cycle after the accepted
      // read and holds until the next accepted read.
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_reg <= '0;
        end else if (rd_ok) begin
          dout_reg <= mem[rd_addr];
        end
      end

      assign data_out = dout_reg;
    end
  endgenerate

  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = af_reg;
  assign almost_empty = ae_reg;
  assign count        = count_reg;
  assign overflow     = ovf_reg;
  assign underflow    = unf_reg;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: drives a standard-mode and an FWFT-mode FIFO with the
// same stimulus and compares both against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AF_T   = 14;
  localparam int AE_T   = 2;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              w_en;
  logic              r_en;
  logic [DATA_W-1:0] data_in;

  logic [DATA_W-1:0] s_dout, f_dout;
  logic              s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic              f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [CW-1:0]     s_count, f_count;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] std_exp;
  logic              exp_ovf;
  logic              exp_unf;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF_T), .AE_THRESH(AE_T), .FWFT(0)
  ) dut_std (
    .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
    .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_param #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF_T), .AE_THRESH(AE_T), .FWFT(1)
  ) dut_fwft (
    .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, compare outputs.
  task automatic step(input logic we, input logic re, input logic [DATA_W-1:0] d,
                      input logic rs, input string tag);
    bit was_full;
    bit was_empty;
    int n;
    @(negedge clk);
    w_en = we; r_en = re; data_in = d; rst = rs;
    @(posedge clk);
    #1;
    if (rs) begin
      q.delete();
      std_exp = '0;
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      exp_ovf   = we & was_full;
      exp_unf   = re & was_empty;
      if (re && !was_empty) std_exp = q.pop_front();
      if (we && !was_full) q.push_back(d);
    end
    n = q.size();
    $display("[TB] %s we=%0d re=%0d din=%02h rst=%0d -> count=%0d dout=%02h fwft=%02h",
             tag, we, re, d, rs, s_count, s_dout, f_dout);
    check({tag, ".count"},     32'(s_count), 32'(n));
    check({tag, ".full"},      32'(s_full),  32'(n == DEPTH));
    check({tag, ".empty"},     32'(s_empty), 32'(n == 0));
    check({tag, ".afull"},     32'(s_af),    32'(n >= AF_T));
    check({tag, ".aempty"},    32'(s_ae),    32'(n <= AE_T));
    check({tag, ".overflow"},  32'(s_ovf),   32'(exp_ovf));
    check({tag, ".underflow"}, 32'(s_unf),   32'(exp_unf));
    check({tag, ".dout_std"},  32'(s_dout),  32'(std_exp));
    check({tag, ".fwft_count"}, 32'(f_count), 32'(n));
    check({tag, ".fwft_empty"}, 32'(f_empty), 32'(n == 0));
    check({tag, ".fwft_ovf"},   32'(f_ovf),   32'(exp_ovf));
    check({tag, ".fwft_unf"},   32'(f_unf),   32'(exp_unf));
    if (n > 0) check({tag, ".dout_fwft"}, 32'(f_dout), 32'(q[0]));
  endtask

  initial begin
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; data_in = '0;
    std_exp = '0; exp_ovf = 1'b0; exp_unf = 1'b0;

    // Power-up reset
    step(0, 0, 8'h00, 1, "reset");
    step(0, 0, 8'h00, 1, "reset");

    // Fill with 0xA0..0xAF
    for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(8'hA0 + i), 0, "fill");

    // Writes into a full FIFO are rejected
    for (int i = 0; i < 3; i++) step(1, 0, 8'hFF, 0, "overflow");

    // Simultaneous read/write while full: read only, overflow pulse
    step(1, 1, 8'h55, 0, "full_rw");

    // Drain everything, then read an empty FIFO
    while (q.size() > 0) step(0, 1, 8'h00, 0, "drain");
    for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0, "underflow");

    // Simultaneous read/write while empty: write only, underflow pulse
    step(1, 1, 8'h66, 0, "empty_rw");
    step(0, 1, 8'h00, 0, "read_66");

    // Steady state at count 8 across several pointer wraps
    for (int i = 0; i < 8; i++) step(1, 0, 8'($urandom), 0, "prefill");
    for (int i = 0; i < 40; i++) step(1, 1, 8'($urandom), 0, "steady");

    // Random traffic, write-biased then read-biased to reach both limits
    for (int i = 0; i < 150; i++)
      step(1'($urandom_range(0, 99) < 75), 1'($urandom_range(0, 99) < 35),
           8'($urandom), 0, "rand_w");
    for (int i = 0; i < 150; i++)
      step(1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 99) < 75),
           8'($urandom), 0, "rand_r");

    // Bring occupancy to 5 and reset mid-operation
    while (q.size() > 5) step(0, 1, 8'h00, 0, "to5");
    while (q.size() < 5) step(1, 0, 8'($urandom), 0, "to5");
    step(0, 0, 8'h00, 1, "mid_reset");
    step(1, 0, 8'h77, 0, "post_rst_wr");
    step(0, 1, 8'h00, 0, "post_rst_rd");

    // First-word-fall-through behaviour
    step(1, 0, 8'h11, 0, "fwft_11");
    step(1, 0, 8'h22, 0, "fwft_22");
    step(0, 0, 8'h00, 0, "fwft_idle");
    step(0, 1, 8'h00, 0, "fwft_pop");
    step(0, 1, 8'h00, 0, "fwft_pop");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised FIFO; next generation of the team's FIFO family for same-domain buffering, where the async version's CDC cost is not needed.
- Adds width/depth parameters, selectable standard or first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty thresholds, an occupancy count, and overflow/underflow error pulses.
- Sits between a producer and consumer in the same clock domain.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=4.
- AF_THRESH, 14, almost_full asserts when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1).
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- w_en  in  1  write request.
- data_in  in  DATA_W  write data, sampled with w_en.
- r_en  in  1  read request (pop).
- data_out  out  DATA_W  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Reset is synchronous, active-high, and dominates all other inputs.
- Reset values: read/write pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, data_out 0, overflow 0, underflow 0. Memory contents are not reset.
- Write accept: wr_ok = w_en & ~full, using the registered full of the current cycle. An accepted write stores data_in at wr_ptr; wr_ptr increments modulo DEPTH.
- Read accept: rd_ok = r_en & ~empty, using the registered empty of the current cycle. rd_ptr increments modulo DEPTH.
- Pointers are $clog2(DEPTH)+1 bits. The extra MSB distinguishes full from empty. count = wr_ptr - rd_ptr, held as a registered value.
- count update per edge: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither.
- All flags are registered and derived from the next count, so they are always consistent with count in the same cycle.
- Simultaneous r_en & w_en:
  - When full: read accepted, write rejected, overflow pulses; full deasserts next cycle.
  - When empty: write accepted, read rejected, underflow pulses.
  - Otherwise both are accepted and count is unchanged.
- overflow = registered (w_en & full); underflow = registered (r_en & empty). Each is high for exactly one cycle per offending request.
- Standard mode (FWFT=0):
  - On rd_ok, data_out <= mem[rd_ptr], visible one cycle after the accepted read.
  - data_out holds its value otherwise, including after the FIFO empties.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] whenever empty=0; r_en acknowledges and pops the head.
  - The first word is valid in the cycle after its write, when empty deasserts.
  - data_out is don't-care while empty=1; the bench must not check it.
- Ordering is strict FIFO across pointer wrap; wrap is seamless with no bubble.
- Reset mid-operation discards all stored data. The cycle after rst deasserts, the FIFO behaves exactly as after power-up reset.

Test Plan:
- Fill/drain, FWFT=0, DEPTH=16: write 0xA0..0xAF on consecutive cycles -> full=1 after the 16th write, count=16, almost_full=1 from count 14. Read 16 -> data_out 0xA0..0xAF, each one cycle after its r_en; empty=1 at the end.
- Overflow: on a full FIFO, 3 writes of 0xFF -> 3 overflow pulses, count stays 16. Subsequent reads return 0xA0.. with no 0xFF.
- Underflow: on an empty FIFO, 3 reads -> 3 underflow pulses, count stays 0, data_out holds 0xAF.
- Simultaneous at the limits:
  - Full + r_en & w_en (data 0x55) -> pops 0xA0, overflow=1, count=15.
  - Empty + r_en & w_en (data 0x66) -> count=1, underflow=1; next read returns 0x66.
- Wrap and steady state: 40 cycles of continuous simultaneous read/write at count=8 -> count stays 8, data in order across 2+ wraps, no flag toggles.
- FWFT=1: write 0x11 -> next cycle empty=0, data_out=0x11 with no r_en. Assert r_en with 0x22 queued -> data_out=0x22 the next cycle.
- Mid-operation reset: with count=5, pulse rst for one cycle -> count=0, empty=1, data_out=0. A following write/read of 0x77 returns 0x77.
